// File: rtl/srff_bank.sv
// srff_bank: a bank of WIDTH independent SR flip-flops with a shared clock.
// The reset is synchronous. Each channel has its own enable.
// When S and R are both asserted, the result is set by CONFLICT_MODE.
// S and R can optionally be edge-triggered.
// The outputs include registered rise/fall pulses and a sticky conflict flag.
module srff_bank #(
  parameter int               WIDTH         = 8,
  parameter int               CONFLICT_MODE = 0,
  parameter int               EDGE_TRIG     = 0,
  parameter logic [WIDTH-1:0] RST_VAL       = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] en,
  input  logic [WIDTH-1:0] s,
  input  logic [WIDTH-1:0] r,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_n,
  output logic [WIDTH-1:0] q_rise,
  output logic [WIDTH-1:0] q_fall,
  output logic             conflict
);

  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_sDly;
  logic [WIDTH-1:0] r_rDly;
  logic [WIDTH-1:0] r_qRise;
  logic [WIDTH-1:0] r_qFall;
  logic             r_conflict;

  logic [WIDTH-1:0] w_es;
  logic [WIDTH-1:0] w_er;
  logic [WIDTH-1:0] w_qNext;
  logic             w_anyConflict;

  // Effective requests and per-channel next state, including the S=R=1 resolution
  always_comb begin
    w_es          = s;
    w_er          = r;
    w_qNext       = r_q;
    w_anyConflict = 1'b0;
    if (EDGE_TRIG != 0) begin
      w_es = s & ~r_sDly;
      w_er = r & ~r_rDly;
    end
    for (int i = 0; i < WIDTH; i++) begin
      if (en[i]) begin
        case ({w_es[i], w_er[i]})
          2'b10: w_qNext[i] = 1'b1;
          2'b01: w_qNext[i] = 1'b0;
          2'b11: begin
            case (CONFLICT_MODE)
              1:       w_qNext[i] = 1'b1;
              2:       w_qNext[i] = 1'b0;
              3:       w_qNext[i] = ~r_q[i];
              default: w_qNext[i] = r_q[i];
            endcase
          end
          default: w_qNext[i] = r_q[i];
        endcase
      end
    end
    w_anyConflict = |(en & w_es & w_er);
  end

  // State, edge-detect history, transition pulses and the sticky conflict flag
  always_ff @(posedge clk) begin
    if (rst) begin
      r_q        <= RST_VAL;
      r_sDly     <= '0;
      r_rDly     <= '0;
      r_qRise    <= '0;
      r_qFall    <= '0;
      r_conflict <= 1'b0;
    end else begin
      r_q        <= w_qNext;
      r_sDly     <= s;
      r_rDly     <= r;
      r_qRise    <= w_qNext & ~r_q;
      r_qFall    <= ~w_qNext & r_q;
      r_conflict <= r_conflict | w_anyConflict;
    end
  end

  assign q        = r_q;
  assign q_n      = ~r_q;
  assign q_rise   = r_qRise;
  assign q_fall   = r_qFall;
  assign conflict = r_conflict;

endmodule
